// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES scan-chain sequencer.
// The scan vector layout is {pt[127:0], key[255:0], pt_sel, key_sel, ct_out_sel}.
package aes_ctrl_pkg;

  localparam int DEF_CHAIN_LEN = 387;
  localparam int DEF_CT_LEN    = 128;

  localparam int PT_W = 128;
  localparam int KEY_W = 256;

  // Field offsets inside the scan vector (bit CHAIN_LEN-1 is shifted first)
  localparam int PT_MSB         = 386;
  localparam int KEY_MSB        = 258;
  localparam int PT_SEL_BIT     = 2;
  localparam int KEY_SEL_BIT    = 1;
  localparam int CT_OUT_SEL_BIT = 0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SHIFT_IN  = 3'd1,
    S_LOAD      = 3'd2,
    S_WAIT_TRIG = 3'd3,
    S_SHIFT_OUT = 3'd4,
    S_DONE      = 3'd5
  } state_e;

endpackage

// File: rtl/aes_trig_counter.sv
// Counts rising edges of the core trigger since the last clear and flags
// completion once TRIG_COUNT edges have been seen and the trigger is low again.
module aes_trig_counter
  import aes_ctrl_pkg::*;
#(
  parameter int TRIG_COUNT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic trigger_i,
  output logic trig_done_o
);

  localparam int CW = $clog2(TRIG_COUNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TRIG_COUNT);

  logic          trig_q, trig_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rising;

  // Edge detect and saturating count; clear wins so edges before the window are dropped
  always_comb begin
    trig_d = trigger_i;
    rising = trigger_i & ~trig_q;
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (rising && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
    trig_done_o = (cnt_q == CNT_MAX) & ~trigger_i;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      trig_q <= trig_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/aes_scan_ctrl.sv
// Scan-chain sequencer for one AES encryption per request: shift the input
// vector in MSB first, pulse load, wait for the core trigger pattern, shift the
// chain out and return the last CT_LEN bits as the ciphertext.
// Optional watchdog in WAIT_TRIG is enabled by defining AES_SCAN_CTRL_TIMEOUT_EN.
//
// Handshake: start_i is a level sampled only in IDLE; busy_o is high from the
// cycle after acceptance until done_o; done_o is a single-cycle pulse and ct_o /
// timeout_o are valid from done_o until the next accepted start.
module aes_scan_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN   = DEF_CHAIN_LEN,
  parameter int CT_LEN      = DEF_CT_LEN,
  parameter int TRIG_COUNT  = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [PT_W-1:0]    pt_i,
  input  logic [KEY_W-1:0]   key_i,
  input  logic               pt_sel_i,
  input  logic               key_sel_i,
  input  logic               ct_out_sel_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [CT_LEN-1:0]  ct_o,
  output logic               timeout_o,
  output logic               sc_en_o,
  output logic               sc_in_o,
  input  logic               sc_out_i,
  output logic               load_o,
  input  logic               trigger_i,
  output logic [2:0]         dbg_state_o
);

  localparam logic [8:0] LAST_BIT = 9'(CHAIN_LEN - 1);

  state_e                 state_q, state_d;
  logic [8:0]             bit_cnt_q, bit_cnt_d;
  logic [CHAIN_LEN-1:0]   shreg_q, shreg_d;
  logic [CT_LEN-1:0]      ct_q, ct_d;
  logic [CHAIN_LEN-1:0]   scan_vec;
  logic                   trig_clr;
  logic                   trig_done;

`ifdef AES_SCAN_CTRL_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT_CYC - 1);
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          timeout_q, timeout_d;
`endif

  aes_trig_counter #(
    .TRIG_COUNT (TRIG_COUNT)
  ) u_trig (
    .clk         (clk),
    .rst         (rst),
    .clr         (trig_clr),
    .trigger_i   (trigger_i),
    .trig_done_o (trig_done)
  );

  // Assemble the scan vector from its fields
  always_comb begin
    scan_vec = '0;
    scan_vec[PT_MSB -: PT_W]    = pt_i;
    scan_vec[KEY_MSB -: KEY_W]  = key_i;
    scan_vec[PT_SEL_BIT]        = pt_sel_i;
    scan_vec[KEY_SEL_BIT]       = key_sel_i;
    scan_vec[CT_OUT_SEL_BIT]    = ct_out_sel_i;
  end

  // Sequencer next-state logic
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    ct_d      = ct_q;
    trig_clr  = 1'b0;
`ifdef AES_SCAN_CTRL_TIMEOUT_EN
    wcnt_d    = wcnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_SHIFT_IN;
          shreg_d   = scan_vec;
          bit_cnt_d = '0;
          ct_d      = '0;
`ifdef AES_SCAN_CTRL_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      S_SHIFT_IN: begin
        shreg_d = {shreg_q[CHAIN_LEN-2:0], 1'b0};
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          state_d   = S_LOAD;
        end else begin
          bit_cnt_d = bit_cnt_q + 9'd1;
        end
      end
      S_LOAD: begin
        trig_clr = 1'b1;
        state_d  = S_WAIT_TRIG;
`ifdef AES_SCAN_CTRL_TIMEOUT_EN
        // The watchdog window starts with the load strobe itself
        wcnt_d   = WW'(1);
`endif
      end
      S_WAIT_TRIG: begin
        if (trig_done) begin
          state_d = S_SHIFT_OUT;
        end
`ifdef AES_SCAN_CTRL_TIMEOUT_EN
        else if (wcnt_q == WLAST) begin
          state_d   = S_DONE;
          ct_d      = '0;
          timeout_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
`endif
      end
      S_SHIFT_OUT: begin
        // Reuse the input shift register to collect the chain contents
        shreg_d = {shreg_q[CHAIN_LEN-2:0], sc_out_i};
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          ct_d      = {shreg_q[CT_LEN-2:0], sc_out_i};
          state_d   = S_DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + 9'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      ct_q      <= '0;
`ifdef AES_SCAN_CTRL_TIMEOUT_EN
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ct_q      <= ct_d;
`ifdef AES_SCAN_CTRL_TIMEOUT_EN
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    sc_en_o     = (state_q == S_SHIFT_IN) || (state_q == S_SHIFT_OUT);
    sc_in_o     = (state_q == S_SHIFT_IN) & shreg_q[CHAIN_LEN-1];
    load_o      = (state_q == S_LOAD);
    done_o      = (state_q == S_DONE);
    busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
    ct_o        = ct_q;
    dbg_state_o = state_q;
`ifdef AES_SCAN_CTRL_TIMEOUT_EN
    timeout_o   = timeout_q;
`else
    timeout_o   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_aes_scan_ctrl.sv
// Directed bench for aes_scan_ctrl with a behavioural scan-chain core model and
// a scoreboard of expected {timeout, ciphertext} results checked on done_o.
// Define AES_SCAN_CTRL_TIMEOUT_EN to exercise the watchdog (TIMEOUT_CYC=16).
module tb_aes_scan_ctrl;
  import aes_ctrl_pkg::*;

  localparam int VW = 387;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic [127:0] pt_i = '0;
  logic [255:0] key_i = '0;
  logic         pt_sel_i = 1'b0, key_sel_i = 1'b0, ct_out_sel_i = 1'b0;
  logic         busy_o, done_o, timeout_o, sc_en_o, sc_in_o, load_o;
  logic [127:0] ct_o;
  logic         sc_out_i;
  logic         trigger_i = 1'b0;
  logic [2:0]   dbg_state_o;

  int n_cmp = 0;
  int n_err = 0;
  int load_cnt = 0;

  logic [128:0]  exp_q[$];
  logic [128:0]  exp_item;
  logic [VW-1:0] chain = '0;
  logic [VW-1:0] last_loaded = '0;
  logic [VW-1:0] vec, stream;

  aes_scan_ctrl #(
    .TIMEOUT_CYC (16)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .pt_i         (pt_i),
    .key_i        (key_i),
    .pt_sel_i     (pt_sel_i),
    .key_sel_i    (key_sel_i),
    .ct_out_sel_i (ct_out_sel_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .ct_o         (ct_o),
    .timeout_o    (timeout_o),
    .sc_en_o      (sc_en_o),
    .sc_in_o      (sc_in_o),
    .sc_out_i     (sc_out_i),
    .load_o       (load_o),
    .trigger_i    (trigger_i),
    .dbg_state_o  (dbg_state_o)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Core model: returns the FIPS-197 AES-256 result for the known vector,
  // otherwise a simple keyed mix so every run has a distinct known answer.
  function automatic logic [127:0] core_ct(input logic [VW-1:0] c);
    logic [127:0] p;
    logic [255:0] k;
    p = c[386:259];
    k = c[258:3];
    if (p == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return p ^ k[255:128] ^ k[127:0];
  endfunction

  assign sc_out_i = chain[VW-1];

  always @(posedge clk) begin
    if (load_o) begin
      chain[127:0] <= core_ct(chain);
      last_loaded  <= chain;
      load_cnt     <= load_cnt + 1;
    end else if (sc_en_o) begin
      chain <= {chain[VW-2:0], sc_in_o};
    end
  end

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done_o pops one expected result
  always @(negedge clk) begin
    if (!rst && done_o === 1'b1) begin
      check("done_expected", VW'(exp_q.size() != 0), VW'(1));
      check("busy_low_at_done", VW'(busy_o), VW'(0));
      if (exp_q.size() != 0) begin
        exp_item = exp_q.pop_front();
        check("ct_o", VW'(ct_o), VW'(exp_item[127:0]));
        check("timeout_o", VW'(timeout_o), VW'(exp_item[128]));
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [127:0] p, input logic [255:0] k, input logic [2:0] s);
    pt_i = p;
    key_i = k;
    {pt_sel_i, key_sel_i, ct_out_sel_i} = s;
    vec = {p, k, s};
  endtask

  task automatic start_txn(input logic [127:0] p, input logic [255:0] k, input logic [2:0] s,
                           input bit push);
    set_inputs(p, k, s);
    if (push) exp_q.push_back({1'b0, core_ct(vec)});
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_state(input state_e st, input int max, input string tag);
    int n = 0;
    while (dbg_state_o !== st && n < max) begin
      tick();
      n++;
    end
    check(tag, VW'(dbg_state_o), VW'(st));
  endtask

  task automatic pulse(input int high, input int low);
    trigger_i = 1'b1;
    repeat (high) tick();
    trigger_i = 1'b0;
    repeat (low) tick();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    int base;
    bit en_ok;
    int n;

    // Reset state
    tick();
    tick();
    check("reset_outputs", VW'({busy_o, done_o, ct_o, timeout_o, sc_en_o, sc_in_o, load_o}), VW'(0));
    check("reset_state", VW'(dbg_state_o), VW'(S_IDLE));
    rst = 1'b0;
    tick();

    // 1. Nominal FIPS-197 AES-256 vector, pulses of 1 and 5 cycles
    base = load_cnt;
    start_txn(FIPS_PT, FIPS_KEY, 3'b110, 1'b1);
    check("busy_after_start", VW'(busy_o), VW'(1));
    stream = '0;
    en_ok = 1'b1;
    for (int i = 0; i < VW; i++) begin
      stream = {stream[VW-2:0], sc_in_o};
      en_ok &= sc_en_o & ~load_o;
      tick();
    end
    check("shift_in_stream", stream, vec);
    check("shift_in_enable", VW'(en_ok), VW'(1));
    check("load_pulse", VW'({load_o, sc_en_o}), VW'(2'b10));
    tick();
    check("load_single", VW'(load_o), VW'(0));
    check("loaded_vec", last_loaded, vec);
    check("load_count", VW'(load_cnt - base), VW'(1));
    pulse(1, 3);
    check("wait_after_1st", VW'(dbg_state_o), VW'(S_WAIT_TRIG));
    pulse(5, 0);
    check("wait_while_high", VW'({sc_en_o, busy_o}), VW'(2'b01));
    tick();
    check("shift_out_start", VW'({dbg_state_o, sc_en_o, sc_in_o}), VW'({S_SHIFT_OUT, 2'b10}));
    repeat (VW) tick();
    check("done_after_shift_out", VW'({done_o, busy_o}), VW'(2'b10));
    tick();
    check("done_one_cycle", VW'({done_o, dbg_state_o}), VW'({1'b0, S_IDLE}));
    check("ct_held", VW'(ct_o), VW'(FIPS_CT));

    // 2. Trigger already high at WAIT_TRIG entry is not counted
    trigger_i = 1'b1;
    start_txn(rnd128(), {rnd128(), rnd128()}, 3'b001, 1'b1);
    wait_state(S_LOAD, 500, "reach_load_t2");
    tick();
    tick();
    tick();
    trigger_i = 1'b0;
    tick();
    tick();
    check("entry_high_ignored", VW'(dbg_state_o), VW'(S_WAIT_TRIG));
    pulse(1, 2);
    check("one_counted_rise", VW'(dbg_state_o), VW'(S_WAIT_TRIG));
    pulse(1, 0);
    check("second_rise_waits", VW'(sc_en_o), VW'(0));
    tick();
    check("first_low_shifts", VW'(dbg_state_o), VW'(S_SHIFT_OUT));
    wait_state(S_DONE, 500, "reach_done_t2");
    tick();

    // 3. start_i held high: one transaction, next accepted right after done
    set_inputs(rnd128(), {rnd128(), rnd128()}, 3'b010);
    exp_q.push_back({1'b0, core_ct(vec)});
    exp_q.push_back({1'b0, core_ct(vec)});
    base = load_cnt;
    start_i = 1'b1;
    tick();
    wait_state(S_WAIT_TRIG, 500, "reach_wait_t3a");
    pulse(1, 2);
    pulse(1, 1);
    wait_state(S_DONE, 500, "reach_done_t3a");
    check("single_load_t3", VW'(load_cnt - base), VW'(1));
    tick();
    check("idle_after_done", VW'({dbg_state_o, busy_o}), VW'({S_IDLE, 1'b0}));
    tick();
    check("restart_after_done", VW'({dbg_state_o, busy_o}), VW'({S_SHIFT_IN, 1'b1}));
    start_i = 1'b0;
    wait_state(S_WAIT_TRIG, 500, "reach_wait_t3b");
    pulse(1, 2);
    pulse(1, 1);
    wait_state(S_DONE, 500, "reach_done_t3b");
    tick();

    // 4. Reset during SHIFT_IN bit 100 and during WAIT_TRIG
    start_txn(rnd128(), {rnd128(), rnd128()}, 3'b111, 1'b0);
    repeat (100) tick();
    rst = 1'b1;
    tick();
    check("rst_shift_in_out", VW'({busy_o, done_o, ct_o, timeout_o, sc_en_o, sc_in_o, load_o}), VW'(0));
    check("rst_shift_in_state", VW'(dbg_state_o), VW'(S_IDLE));
    rst = 1'b0;
    tick();
    start_txn(rnd128(), {rnd128(), rnd128()}, 3'b100, 1'b0);
    wait_state(S_WAIT_TRIG, 500, "reach_wait_t4");
    pulse(1, 1);
    rst = 1'b1;
    tick();
    check("rst_wait_out", VW'({busy_o, done_o, ct_o, timeout_o, sc_en_o, sc_in_o, load_o}), VW'(0));
    check("rst_wait_state", VW'(dbg_state_o), VW'(S_IDLE));
    rst = 1'b0;
    tick();
    start_txn(FIPS_PT, FIPS_KEY, 3'b011, 1'b1);
    wait_state(S_WAIT_TRIG, 500, "reach_wait_t4b");
    pulse(1, 1);
    check("count_cleared_by_rst", VW'(dbg_state_o), VW'(S_WAIT_TRIG));
    pulse(1, 1);
    wait_state(S_DONE, 500, "reach_done_t4b");
    tick();

    // 5. No trigger at all
`ifdef AES_SCAN_CTRL_TIMEOUT_EN
    set_inputs(rnd128(), {rnd128(), rnd128()}, 3'b000);
    exp_q.push_back({1'b1, 128'h0});
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_state(S_LOAD, 500, "reach_load_t5");
    n = 0;
    while (done_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("timeout_latency", VW'(n), VW'(16));
    tick();
`else
    start_txn(rnd128(), {rnd128(), rnd128()}, 3'b000, 1'b0);
    wait_state(S_WAIT_TRIG, 500, "reach_wait_t5");
    repeat (200) tick();
    check("no_trigger_busy", VW'({busy_o, done_o, timeout_o}), VW'(3'b100));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`endif

    // 6. Trigger pulses in IDLE and SHIFT_IN are ignored
    pulse(2, 2);
    start_txn(rnd128(), {rnd128(), rnd128()}, 3'b101, 1'b1);
    repeat (10) tick();
    pulse(1, 3);
    pulse(3, 3);
    wait_state(S_WAIT_TRIG, 500, "reach_wait_t6");
    pulse(1, 5);
    check("stale_edges_ignored", VW'({dbg_state_o, sc_en_o}), VW'({S_WAIT_TRIG, 1'b0}));
    pulse(1, 1);
    check("two_fresh_edges", VW'(dbg_state_o), VW'(S_SHIFT_OUT));
    wait_state(S_DONE, 500, "reach_done_t6");
    tick();
    tick();

    check("queue_drained", VW'(exp_q.size()), VW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
